// File: rtl/multicore_timer_mc.sv
// multicore_timer_mc: NUM_CH independent prescaled down-counters behind one Avalon-MM slave.
// Each channel drives its own irq_ch bit (TO & ITO); irq is their OR.
module multicore_timer_mc #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned COUNTER_W    = 32,
    parameter int unsigned PRESCALE_W   = 16,
    parameter int unsigned RESET_PERIOD = 99,
    parameter int unsigned CH_AW        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH_AW+2:0]  address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] irq_ch,
    output logic              irq
);

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_PERIOD   = 3'd2,
        REG_SNAP     = 3'd3,
        REG_PRESCALE = 3'd4,
        REG_RSVD5    = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_e;

    logic [CH_AW-1:0]      w_ch;
    reg_e                  w_reg;
    logic                  w_wr;
    logic [31:0]           w_rdata;

    logic [COUNTER_W-1:0]  r_count    [NUM_CH];
    logic [COUNTER_W-1:0]  r_period   [NUM_CH];
    logic [COUNTER_W-1:0]  r_snap     [NUM_CH];
    logic [PRESCALE_W-1:0] r_prescale [NUM_CH];
    logic [PRESCALE_W-1:0] r_pcount   [NUM_CH];
    logic [NUM_CH-1:0]     r_run;
    logic [NUM_CH-1:0]     r_to;
    logic [NUM_CH-1:0]     r_cont;
    logic [NUM_CH-1:0]     r_ito;
    logic [NUM_CH-1:0]     r_reload;

    logic [NUM_CH-1:0]     w_tick;
    logic [NUM_CH-1:0]     w_timeout;
    logic [NUM_CH-1:0]     w_wsel;

    assign w_ch  = address[CH_AW+2:3];
    assign w_reg = reg_e'(address[2:0]);
    assign w_wr  = chipselect & ~write_n;

    always_comb begin
        w_tick    = '0;
        w_timeout = '0;
        w_wsel    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_tick[i]    = r_run[i] && (r_pcount[i] == '0);
            w_timeout[i] = w_tick[i] && (r_count[i] == '0);
            w_wsel[i]    = w_wr && (w_ch == CH_AW'(i));
        end
    end

    // Channels at or above NUM_CH never match, so they read as zero.
    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_ch == CH_AW'(i)) begin
                case (w_reg)
                    REG_STATUS:   w_rdata = {30'b0, r_run[i], r_to[i]};
                    REG_CONTROL:  w_rdata = {28'b0, 2'b00, r_cont[i], r_ito[i]};
                    REG_PERIOD:   w_rdata = 32'(r_period[i]);
                    REG_SNAP:     w_rdata = 32'(r_snap[i]);
                    REG_PRESCALE: w_rdata = 32'(r_prescale[i]);
                    default:      w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            r_run    <= '0;
            r_to     <= '0;
            r_cont   <= '0;
            r_ito    <= '0;
            r_reload <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_count[i]    <= COUNTER_W'(RESET_PERIOD);
                r_period[i]   <= COUNTER_W'(RESET_PERIOD);
                r_snap[i]     <= '0;
                r_prescale[i] <= '0;
                r_pcount[i]   <= '0;
            end
        end else begin
            readdata <= w_rdata;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_reload[i] <= 1'b0;

                if (!r_run[i]) begin
                    r_pcount[i] <= '0;
                end else if (r_pcount[i] == '0) begin
                    r_pcount[i] <= r_prescale[i];
                end else begin
                    r_pcount[i] <= r_pcount[i] - PRESCALE_W'(1);
                end

                if (r_reload[i]) begin
                    r_count[i] <= r_period[i];
                end else if (w_tick[i]) begin
                    if (r_count[i] != '0) begin
                        r_count[i] <= r_count[i] - COUNTER_W'(1);
                    end else begin
                        r_count[i] <= r_period[i];
                        r_to[i]    <= 1'b1;
                        if (!r_cont[i]) r_run[i] <= 1'b0;
                    end
                end

                // Bus writes come last so START/STOP override a same-edge one-shot stop.
                if (w_wsel[i]) begin
                    case (w_reg)
                        REG_STATUS: begin
                            if (!w_timeout[i]) r_to[i] <= 1'b0;
                        end
                        REG_CONTROL: begin
                            r_cont[i] <= writedata[1];
                            r_ito[i]  <= writedata[0];
                            if (writedata[2])      r_run[i] <= 1'b1;
                            else if (writedata[3]) r_run[i] <= 1'b0;
                        end
                        REG_PERIOD: begin
                            r_period[i] <= writedata[COUNTER_W-1:0];
                            r_run[i]    <= 1'b0;
                            r_reload[i] <= 1'b1;
                        end
                        REG_SNAP:     r_snap[i]     <= r_count[i];
                        REG_PRESCALE: r_prescale[i] <= writedata[PRESCALE_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign irq_ch = r_to & r_ito;
    assign irq    = |irq_ch;

endmodule

// File: tb/tb_multicore_timer_mc.sv
// Bench for multicore_timer_mc: vector table, directed timing sequences and a random
// bus phase, all checked against a per-channel behavioural model.
module tb_multicore_timer_mc;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CH_AW = 3;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              chipselect = 1'b0;
    logic              write_n    = 1'b1;
    logic [CH_AW+2:0]  address    = '0;
    logic [31:0]       writedata  = '0;
    logic [31:0]       readdata;
    logic [NCH-1:0]    irq_ch;
    logic              irq;

    int n_chk  = 0;
    int n_fail = 0;

    multicore_timer_mc #(
        .NUM_CH(NCH), .COUNTER_W(32), .PRESCALE_W(16), .RESET_PERIOD(99), .CH_AW(CH_AW)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq_ch(irq_ch), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: m_wait = clocks left before the next tick while running.
    logic [31:0] m_count [NCH];
    logic [31:0] m_period[NCH];
    logic [31:0] m_snap  [NCH];
    logic [31:0] m_pre   [NCH];
    logic [31:0] m_wait  [NCH];
    bit          m_run   [NCH];
    bit          m_to    [NCH];
    bit          m_cont  [NCH];
    bit          m_ito   [NCH];
    bit          m_reload[NCH];

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_count[i] = 99; m_period[i] = 99; m_snap[i] = 0; m_pre[i] = 0; m_wait[i] = 0;
            m_run[i] = 0; m_to[i] = 0; m_cont[i] = 0; m_ito[i] = 0; m_reload[i] = 0;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] a);
        int unsigned ch = a / 8;
        int unsigned rg = a % 8;
        if (ch >= NCH) return 0;
        case (rg)
            0: return {30'b0, m_run[ch], m_to[ch]};
            1: return {30'b0, m_cont[ch], m_ito[ch]};
            2: return m_period[ch];
            3: return m_snap[ch];
            4: return m_pre[ch];
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_irq();
        logic [3:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_to[i] & m_ito[i];
        return v;
    endfunction

    function automatic void model_edge(input bit we, input logic [5:0] a, input logic [31:0] d);
        int unsigned ch = a / 8;
        int unsigned rg = a % 8;
        for (int i = 0; i < NCH; i++) begin
            bit          tick  = m_run[i] && (m_wait[i] == 0);
            bit          tmo   = tick && (m_count[i] == 0);
            logic [31:0] c_old = m_count[i];
            if (!m_run[i])          m_wait[i] = 0;
            else if (m_wait[i] == 0) m_wait[i] = m_pre[i];
            else                     m_wait[i] = m_wait[i] - 1;
            if (m_reload[i]) begin
                m_count[i]  = m_period[i];
                m_reload[i] = 0;
            end else if (tmo) begin
                m_count[i] = m_period[i];
                m_to[i]    = 1;
                if (!m_cont[i]) m_run[i] = 0;
            end else if (tick) begin
                m_count[i] = c_old - 1;
            end
            if (we && ch == i) begin
                case (rg)
                    0: if (!tmo) m_to[i] = 0;
                    1: begin
                        m_cont[i] = d[1];
                        m_ito[i]  = d[0];
                        if (d[2])      m_run[i] = 1;
                        else if (d[3]) m_run[i] = 0;
                    end
                    2: begin m_period[i] = d; m_run[i] = 0; m_reload[i] = 1; end
                    3: m_snap[i] = c_old;
                    4: m_pre[i]  = {16'b0, d[15:0]};
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] A(input int unsigned ch, input int unsigned rg);
        return 6'(ch * 8 + rg);
    endfunction

    // One bus cycle: drive, clock, then compare against the model.
    task automatic bus(input logic cs, input logic we, input logic [5:0] a, input logic [31:0] d);
        logic [31:0] exp_rd;
        chipselect = cs;
        write_n    = ~we;
        address    = a;
        writedata  = d;
        exp_rd     = model_read(a);
        @(posedge clk);
        model_edge(cs && we, a, d);
        #1;
        chk("readdata", readdata, exp_rd);
        chk("irq_ch", {28'b0, irq_ch}, {28'b0, model_irq()});
        chk("irq", {31'b0, irq}, {31'b0, |model_irq()});
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input int unsigned ch, input int unsigned rg, input logic [31:0] d);
        bus(1'b1, 1'b1, A(ch, rg), d);
    endtask

    task automatic rd(input int unsigned ch, input int unsigned rg);
        bus(1'b1, 1'b0, A(ch, rg), '0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) bus(1'b0, 1'b0, address, '0);
    endtask

    typedef struct {
        logic        cs;
        logic        we;
        logic [5:0]  a;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];
    int   rises[$];

    initial begin
        int  n;
        bit  clr;

        model_reset();
        #20;
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_irq_ch", {28'b0, irq_ch}, 32'd0);
        #2 reset = 1'b0;

        vt.push_back('{1'b1, 1'b0, A(0, 2), 32'd0,        1'b1, 32'd99});
        vt.push_back('{1'b1, 1'b0, A(0, 0), 32'd0,        1'b1, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(0, 4), 32'd0,        1'b1, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(0, 3), 32'd0,        1'b1, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(0, 1), 32'd0,        1'b1, 32'd0});
        vt.push_back('{1'b0, 1'b1, A(0, 2), 32'd5,        1'b0, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(0, 2), 32'd0,        1'b1, 32'd99});
        vt.push_back('{1'b1, 1'b1, A(3, 4), 32'hAB1234,   1'b0, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(3, 4), 32'd0,        1'b1, 32'h1234});
        vt.push_back('{1'b1, 1'b1, A(3, 1), 32'h3,        1'b0, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(3, 1), 32'd0,        1'b1, 32'd3});
        vt.push_back('{1'b1, 1'b1, A(5, 2), 32'd7,        1'b0, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(5, 2), 32'd0,        1'b1, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(1, 2), 32'd0,        1'b1, 32'd99});
        vt.push_back('{1'b1, 1'b0, A(3, 6), 32'd0,        1'b1, 32'd0});
        vt.push_back('{1'b1, 1'b1, A(3, 5), 32'hFFFF,     1'b0, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(3, 5), 32'd0,        1'b1, 32'd0});
        vt.push_back('{1'b1, 1'b1, A(3, 1), 32'h0,        1'b0, 32'd0});
        vt.push_back('{1'b1, 1'b1, A(3, 4), 32'h0,        1'b0, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(3, 1), 32'd0,        1'b1, 32'd0});
        vt.push_back('{1'b1, 1'b0, A(3, 4), 32'd0,        1'b1, 32'd0});

        foreach (vt[k]) begin
            bus(vt[k].cs, vt[k].we, vt[k].a, vt[k].wd);
            if (vt[k].chk) chk($sformatf("vec%0d", k), readdata, vt[k].exp);
        end

        // One-shot: PERIOD=9, START|ITO -> irq_ch[1] ten edges after START.
        wr(1, 2, 9);
        wr(1, 1, 32'h5);
        n = 31;
        for (int c = 1; c <= 30; c++) begin
            idle(1);
            if (irq_ch[1]) begin n = c; break; end
        end
        chk("oneshot_latency", n, 10);
        rd(1, 0);
        chk("oneshot_status", readdata, 32'd1);
        wr(1, 3, 0);
        rd(1, 3);
        chk("oneshot_count", readdata, 32'd9);
        wr(1, 0, 0);
        chk("oneshot_clear", {31'b0, irq}, 32'd0);

        // Continuous with prescaler: first TO 17 edges after START, then every 20.
        wr(2, 2, 4);
        wr(2, 4, 3);
        wr(2, 1, 32'h7);
        clr = 0;
        for (int c = 1; c <= 120; c++) begin
            bus(1'b1, clr, A(2, 0), '0);
            clr = irq_ch[2];
            if (irq_ch[2]) rises.push_back(c);
        end
        chk("cont_nrises", rises.size() >= 4 ? 32'd1 : 32'd0, 32'd1);
        if (rises.size() >= 1) chk("cont_first", rises[0], 17);
        for (int k = 1; k < 4 && k < rises.size(); k++)
            chk($sformatf("cont_interval%0d", k), rises[k] - rises[k-1], 20);
        wr(2, 1, 32'h8);
        wr(2, 0, 0);

        // STATUS write on the timeout edge: set wins; next write clears.
        wr(1, 1, 32'h5);
        idle(9);
        chk("setwin_before", {31'b0, irq}, 32'd0);
        wr(1, 0, 0);
        chk("setwin_irq", {31'b0, irq}, 32'd1);
        wr(1, 0, 0);
        chk("setwin_to_read", readdata, 32'd1);
        chk("setwin_cleared", {31'b0, irq}, 32'd0);

        // SNAP mid-count and START|STOP priority.
        wr(0, 2, 1000);
        wr(0, 1, 32'h4);
        idle(400);
        wr(0, 3, 0);
        rd(0, 3);
        chk("snap_600", readdata, 32'd600);
        wr(0, 1, 32'hC);
        rd(0, 0);
        chk("startstop_run", readdata, 32'd2);
        wr(0, 1, 32'h8);
        rd(0, 0);
        chk("stop_run", readdata, 32'd0);

        // Out-of-range channel 5 must not alias onto channel 1.
        wr(5, 1, 32'h7);
        rd(5, 1);
        chk("ch5_read", readdata, 32'd0);
        rd(1, 1);
        chk("ch1_untouched", readdata, 32'd1);

        // Asynchronous reset while ch3 is counting with irq pending.
        wr(3, 2, 2);
        wr(3, 1, 32'h7);
        idle(5);
        chk("pre_reset_irq", {31'b0, irq}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_irq", {31'b0, irq}, 32'd0);
        chk("async_irq_ch", {28'b0, irq_ch}, 32'd0);
        chk("async_readdata", readdata, 32'd0);
        model_reset();
        #1 reset = 1'b0;
        rd(3, 0);
        chk("post_reset_status", readdata, 32'd0);
        wr(3, 3, 0);
        rd(3, 3);
        chk("post_reset_count", readdata, 32'd99);
        idle(5);
        rd(3, 0);
        chk("post_reset_norun", readdata, 32'd0);

        // Random bus traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            int unsigned ch = $urandom_range(0, 5);
            int unsigned rg = $urandom_range(0, 7);
            logic        cs = ($urandom_range(0, 9) != 0);
            logic [31:0] d;
            case (rg)
                1:       d = $urandom_range(0, 15);
                2:       d = $urandom_range(0, 12);
                4:       d = $urandom_range(0, 3);
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 99) < 25) bus(cs, 1'b1, A(ch, rg), d);
            else                            bus(cs, 1'b0, A(ch, rg), '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
